// File: rtl/branch_predictor.sv
// branch_predictor: 2-bit counter direction predictor with BTB and registered mispredict redirect.
// Ports: clk, rst_n (async active-low); f_pc -> f_pred_taken/f_pred_target (combinational lookup);
// ex_valid/ex_pc/ex_target/ex_taken/ex_pred_taken (training); redirect/redirect_pc (1-cycle flush);
// br_count/mis_count only when BP_STATS_EN is defined.
module branch_predictor #(
    parameter int DATAW = 32,
    parameter int ENTRIES = 64,
    localparam int IDXW = $clog2(ENTRIES)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [DATAW-1:0] f_pc,
    output logic             f_pred_taken,
    output logic [DATAW-1:0] f_pred_target,
    input  logic             ex_valid,
    input  logic [DATAW-1:0] ex_pc,
    input  logic [DATAW-1:0] ex_target,
    input  logic             ex_taken,
    input  logic             ex_pred_taken,
    output logic             redirect,
    output logic [DATAW-1:0] redirect_pc
`ifdef BP_STATS_EN
    ,
    output logic [31:0]      br_count,
    output logic [31:0]      mis_count
`endif
);
    localparam int TAGW = DATAW - IDXW - 2;

    logic             valid  [ENTRIES];
    logic [1:0]       ctr    [ENTRIES];
    logic [TAGW-1:0]  tag    [ENTRIES];
    logic [DATAW-1:0] target [ENTRIES];

    logic [IDXW-1:0] f_idx, e_idx;
    logic            f_hit, e_hit, mispredict;

    assign f_idx         = f_pc[IDXW+1:2];
    assign f_hit         = valid[f_idx] && tag[f_idx] == f_pc[DATAW-1:IDXW+2];
    assign f_pred_taken  = f_hit && ctr[f_idx][1];
    assign f_pred_target = f_pred_taken ? target[f_idx] : f_pc + DATAW'(4);

    assign e_idx      = ex_pc[IDXW+1:2];
    assign e_hit      = valid[e_idx] && tag[e_idx] == ex_pc[DATAW-1:IDXW+2];
    assign mispredict = ex_valid && (ex_pred_taken != ex_taken);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid[i] <= 1'b0;
                ctr[i]   <= 2'd1;
            end
            redirect    <= 1'b0;
            redirect_pc <= '0;
        end else begin
            if (ex_valid) begin
                if (e_hit)
                    ctr[e_idx] <= ex_taken ? (ctr[e_idx] == 2'd3 ? 2'd3 : ctr[e_idx] + 2'd1)
                                           : (ctr[e_idx] == 2'd0 ? 2'd0 : ctr[e_idx] - 2'd1);
                else if (ex_taken) begin
                    valid[e_idx] <= 1'b1;
                    ctr[e_idx]   <= 2'd2;
                end
            end
            redirect <= mispredict;
            if (mispredict)
                redirect_pc <= ex_taken ? ex_target : ex_pc + DATAW'(4);
        end
    end

    // Tag/target only matter while valid=1, so they need no reset.
    always_ff @(posedge clk) begin
        if (ex_valid && ex_taken) begin
            target[e_idx] <= ex_target;
            if (!e_hit)
                tag[e_idx] <= ex_pc[DATAW-1:IDXW+2];
        end
    end

`ifdef BP_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            br_count  <= '0;
            mis_count <= '0;
        end else begin
            if (ex_valid)
                br_count <= br_count + 32'd1;
            if (mispredict)
                mis_count <= mis_count + 32'd1;
        end
    end
`endif
endmodule

// File: doc/branch_predictor.md
# branch_predictor

- Direction predictor and branch target buffer (BTB) for the RV32 core.
- At fetch, it looks up the PC and predicts whether a conditional branch is taken and where it goes.
- At execute, it takes the resolved outcome from the branch comparator (`taken`), trains its 2-bit saturating counters and BTB, and raises a registered redirect on a misprediction.
- It sits between the execute-stage branch comparator and the fetch-stage PC mux.

## Interface

Parameters:
- `DATAW`, 32, datapath/PC width
- `ENTRIES`, 64, number of predictor entries; power of two, at least 4
- `IDXW`, `$clog2(ENTRIES)`, index width; derived, not overridden

Ports:
- `clk` input 1: core clock; all state updates on the rising edge
- `rst_n` input 1: asynchronous, active-low reset
- `f_pc` input DATAW: fetch-stage PC
- `f_pred_taken` output 1: prediction for `f_pc`
- `f_pred_target` output DATAW: next fetch PC as predicted
- `ex_valid` input 1: a conditional branch resolves this cycle
- `ex_pc` input DATAW: PC of the resolving branch
- `ex_target` input DATAW: computed branch target (`ex_pc` + B-immediate)
- `ex_taken` input 1: resolved direction from the branch comparator
- `ex_pred_taken` input 1: the `f_pred_taken` value carried down the pipeline with this branch
- `redirect` output 1: one-cycle flush/redirect pulse to fetch
- `redirect_pc` output DATAW: correct next PC, valid while `redirect`=1
- `br_count` output 32: resolved-branch count; present only with `BP_STATS_EN`
- `mis_count` output 32: misprediction count; present only with `BP_STATS_EN`

## Operation

Addressing:
- index = `pc[IDXW+1:2]`
- tag = `pc[DATAW-1:IDXW+2]`
- Bits [1:0] are ignored.

Entry state:
- `valid` (1 bit), `tag`, `target` (DATAW), `ctr` (2 bits).
- Counter states: 0 strong not-taken (SNT), 1 weak not-taken (WNT), 2 weak taken (WT), 3 strong taken (ST).

Lookup (combinational on `f_pc`):
- A hit is `valid` && tag match.
- On a hit with `ctr[1]`=1: `f_pred_taken`=1 and `f_pred_target`=`target`.
- Otherwise: `f_pred_taken`=0 and `f_pred_target`=`f_pc`+4, with 32-bit wrap.

Update (clock edge with `ex_valid`=1), indexed by `ex_pc`:
- **Hit, taken:** `ctr` = min(`ctr`+1, 3); `target` ← `ex_target`.
- **Hit, not taken:** `ctr` = max(`ctr`−1, 0); tag and target unchanged.
- **Miss, taken:** allocate and overwrite the entry: `valid`=1, `tag`, `target`=`ex_target`, `ctr`=2 (WT).
- **Miss, not taken:** no state change.

Misprediction:
- mispredict = `ex_valid` && (`ex_pred_taken` != `ex_taken`).
- Target mismatch is not checked, because tags are full-width and targets are PC-relative.
- On a mispredict, the next edge sets `redirect`=1 and `redirect_pc` = `ex_taken` ? `ex_target` : `ex_pc`+4.
- On any edge without a mispredict, `redirect`=0 and `redirect_pc` holds its last value.

## Timing

Reset (async assert, sync-safe deassert):
- All `valid`=0 and all `ctr`=1 (WNT).
- `redirect`=0, `redirect_pc`=0, `br_count`=0, `mis_count`=0.
- A pending redirect is discarded.

Latencies:
- Lookup: 0 cycles; `f_pred_*` depend only on `f_pc` and current state.
- Update: takes effect at the edge ending the `ex_valid` cycle and is visible to lookups the next cycle.
- Redirect: asserted exactly 1 cycle after the mispredicting `ex_valid` cycle, for exactly 1 cycle.

Boundary conditions:
- **Same index, same cycle:** when lookup and update hit the same index, the lookup returns the pre-update value; no bypass.
- **Back-to-back branches:** `ex_valid` on consecutive cycles is processed independently. Two consecutive mispredicts give `redirect` high two cycles with the respective PCs; the pipeline flush guarantees this does not occur in practice, but the block must not drop either.
- **PC wrap:** `ex_pc`=0xFFFFFFFC not taken gives `redirect_pc`=0x00000000.
- **Aliasing:** a miss-taken update to an index holding another tag evicts it, and its counter restarts at WT.

## Configuration

`BP_STATS_EN`:
- **Defined:**
  - `br_count` increments on each `ex_valid` cycle.
  - `mis_count` increments on each mispredict.
  - Both are 32-bit free-running, wrap from 0xFFFFFFFF to 0, and are registered (updated at the same edge as the training update).
- **Undefined:** both ports and counters are absent; the remaining behaviour is identical.

## Test plan

- **Post-reset lookup:** after reset, `f_pc`=0x100 → `f_pred_taken`=0, `f_pred_target`=0x104, `redirect`=0.
- **Allocate and predict taken:** `ex_valid`, `ex_pc`=0x100, `ex_target`=0x80, `ex_taken`=1, `ex_pred_taken`=0.
  - Next cycle: `redirect`=1 and `redirect_pc`=0x80.
  - Afterwards `f_pc`=0x100 → `f_pred_taken`=1 and `f_pred_target`=0x80.
- **Counter saturation (entry from the previous scenario):**
  - Three taken updates leave `ctr`=3.
  - Then two not-taken updates: still predicts taken after the first, predicts not-taken (target 0x104) after the second.
  - Four further not-taken updates leave `ctr` at 0 with no underflow.
- **Aliasing (default `ENTRIES`=64):**
  - Taken at 0x100 then taken at 0x200 (same index, different tag): lookup 0x100 → not taken (miss), and 0x200 → taken.
  - A not-taken miss at 0x300 leaves the entry untouched.
- **Read-during-write, wrap and reset:**
  - Lookup and update of 0x100 in the same cycle returns the old prediction.
  - `ex_pc`=0xFFFFFFFC, not taken, predicted taken → `redirect_pc`=0.
  - Asserting `rst_n`=0 in the cycle the redirect is due → `redirect` stays 0.
- **Stats (with `BP_STATS_EN`):** 10 branches with 3 mispredicts → `br_count`=10, `mis_count`=3; a preset of 0xFFFFFFFF wraps to 0.
